mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store traffic onto a byte-wide RAM.
// Optional MEM_CTRL_IO_STALL_EN holds off stores to the UART window while its buffer is full.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        lsb_valid,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic        lsb_signed,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_data,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            owner_lsb, owner_lsb_nxt;
    logic [AW-1:0]   req_addr, req_addr_nxt;
    logic [1:0]      req_len, req_len_nxt;
    logic            req_signed, req_signed_nxt;
    logic [DW-1:0]   req_wdata, req_wdata_nxt;
    logic [DW-1:0]   rbuf, rbuf_nxt;

    logic            if_done_nxt, lsb_done_nxt, mem_wr_nxt;
    logic [DW-1:0]   if_inst_nxt, lsb_rdata_nxt;
    logic [7:0]      mem_dout_nxt;
    logic [AW-1:0]   mem_a_nxt;

    logic            io_stall, lsb_go, accept_lsb, accept_if, last_rd;
    logic [CW-1:0]   nbytes;
    logic [1:0]      byte_idx;
    logic [DW-1:0]   rd_ext;

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = lsb_wr && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign io_stall = 1'b0;
`endif

    // Request decode shared by next-state and output logic
    always_comb begin
        case (req_len)
            2'd0:    nbytes = CW'(1);
            2'd1:    nbytes = CW'(2);
            default: nbytes = CW'(4);
        endcase
        lsb_go     = lsb_valid && !io_stall;
        accept_lsb = (state == IDLE) && !rollback && lsb_go;
        accept_if  = (state == IDLE) && !rollback && !lsb_go && if_valid;
        last_rd    = (state == READ) && !rollback && (cnt == nbytes + CW'(1));
        byte_idx   = 2'(cnt - CW'(2));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_lsb  <= 1'b0;
            req_addr   <= '0;
            req_len    <= '0;
            req_signed <= 1'b0;
            req_wdata  <= '0;
            rbuf       <= '0;
            if_done    <= 1'b0;
            lsb_done   <= 1'b0;
            if_inst    <= '0;
            lsb_rdata  <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
        end else if (rdy) begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            owner_lsb  <= owner_lsb_nxt;
            req_addr   <= req_addr_nxt;
            req_len    <= req_len_nxt;
            req_signed <= req_signed_nxt;
            req_wdata  <= req_wdata_nxt;
            rbuf       <= rbuf_nxt;
            if_done    <= if_done_nxt;
            lsb_done   <= lsb_done_nxt;
            if_inst    <= if_inst_nxt;
            lsb_rdata  <= lsb_rdata_nxt;
            mem_a      <= mem_a_nxt;
            mem_dout   <= mem_dout_nxt;
            mem_wr     <= mem_wr_nxt;
        end
    end

    // Next-state: cnt counts edges since acceptance; RAM bytes arrive two edges after their address
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        owner_lsb_nxt  = owner_lsb;
        req_addr_nxt   = req_addr;
        req_len_nxt    = req_len;
        req_signed_nxt = req_signed;
        req_wdata_nxt  = req_wdata;
        rbuf_nxt       = rbuf;
        case (state)
            IDLE: begin
                if (accept_lsb) begin
                    state_nxt      = lsb_wr ? WRITE : READ;
                    cnt_nxt        = CW'(1);
                    owner_lsb_nxt  = 1'b1;
                    req_addr_nxt   = lsb_addr;
                    req_len_nxt    = lsb_len;
                    req_signed_nxt = lsb_signed;
                    req_wdata_nxt  = lsb_data;
                    rbuf_nxt       = '0;
                end else if (accept_if) begin
                    state_nxt      = READ;
                    cnt_nxt        = CW'(1);
                    owner_lsb_nxt  = 1'b0;
                    req_addr_nxt   = if_addr;
                    req_len_nxt    = 2'd2;
                    req_signed_nxt = 1'b0;
                    rbuf_nxt       = '0;
                end
            end
            READ: begin
                if (rollback) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    if (cnt >= CW'(2)) rbuf_nxt[{byte_idx, 3'b000} +: 8] = mem_din;
                    if (last_rd) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            WRITE: begin
                if (cnt == nbytes) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output next values: address/data stream, done pulses and extended read result
    always_comb begin
        mem_a_nxt     = mem_a;
        mem_dout_nxt  = mem_dout;
        mem_wr_nxt    = 1'b0;
        if_done_nxt   = 1'b0;
        lsb_done_nxt  = 1'b0;
        if_inst_nxt   = if_inst;
        lsb_rdata_nxt = lsb_rdata;
        case (req_len)
            2'd0:    rd_ext = {{24{req_signed & rbuf_nxt[7]}}, rbuf_nxt[7:0]};
            2'd1:    rd_ext = {{16{req_signed & rbuf_nxt[15]}}, rbuf_nxt[15:0]};
            default: rd_ext = rbuf_nxt;
        endcase
        case (state)
            IDLE: begin
                if (accept_lsb) begin
                    mem_a_nxt = lsb_addr;
                    if (lsb_wr) begin
                        mem_dout_nxt = lsb_data[7:0];
                        mem_wr_nxt   = 1'b1;
                    end
                end else if (accept_if) begin
                    mem_a_nxt = if_addr;
                end
            end
            READ: begin
                if (!rollback) begin
                    if (cnt < nbytes) mem_a_nxt = req_addr + AW'(cnt);
                    if (last_rd) begin
                        if (owner_lsb) begin
                            lsb_done_nxt  = 1'b1;
                            lsb_rdata_nxt = rd_ext;
                        end else begin
                            if_done_nxt = 1'b1;
                            if_inst_nxt = rd_ext;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt < nbytes) begin
                    mem_a_nxt    = req_addr + AW'(cnt);
                    mem_dout_nxt = req_wdata[{cnt[1:0], 3'b000} +: 8];
                    mem_wr_nxt   = 1'b1;
                end else begin
                    lsb_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule
